// File: rtl/multicycle_shifter.sv
// Iterative 32-bit shifter: one bit position per clock, valid/ready on both sides.
// Bit-exact with the combinational shifter for SLL/SRL/SRA; encoding 01 is rotate-right.
module multicycle_shifter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [4:0]            B,
    input  logic [1:0]            Shiftop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StShift = 2'b01;
    localparam logic [1:0] StDone  = 2'b10;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b10;
    localparam logic [1:0] OpSra = 2'b11;

    logic [1:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] step;

    always_comb begin
        case (op_q)
            OpSll:   step = {data_q[DATA_WIDTH-2:0], 1'b0};
            OpSrl:   step = {1'b0, data_q[DATA_WIDTH-1:1]};
            OpSra:   step = {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
            default: step = {data_q[0], data_q[DATA_WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = A;
                    op_d    = Shiftop;
                    cnt_d   = B;
                    state_d = StShift;
                end
            end
            StShift: begin
                // A zero amount spends one pass-through cycle so latency is max(B,1).
                if (cnt_q == 5'd0) begin
                    state_d = StDone;
                end else begin
                    data_d = step;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            cnt_q   <= 5'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Result    = data_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed and randomized checks of multicycle_shifter: results, latency, backpressure, reset.
module tb_multicycle_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [4:0]  B;
    logic [1:0]  Shiftop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_shifter #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Shiftop   (Shiftop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic [1:0] op);
        int unsigned sh;
        sh = b;
        case (op)
            2'b00:   return a << sh;
            2'b10:   return a >> sh;
            2'b11:   return $signed(a) >>> sh;
            default: return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
        endcase
    endfunction

    // Issue one request, measure latency, optionally hold backpressure and poke a request while busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] op, input logic [31:0] exp, input int hold,
                          input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (b == 5'd0) ? 1 : int'(b);
        check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Shiftop  = op;
        @(posedge clk);
        #1;
        if (poke) begin
            A       = 32'h0;
            B       = 5'd3;
            Shiftop = 2'b00;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (poke) check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, Result, exp);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_result"}, Result, exp);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, "_no_ghost_op"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int spur;
        int guard;
        logic [31:0] ra;
        logic [4:0]  rb;
        logic [1:0]  rop;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Shiftop   = '0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        #22;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_in_ready", {31'd0, in_ready}, 32'd1);
            check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            check("idle_result", Result, 32'h0);
        end

        run_op("sll_max",   32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 0, 1'b0);
        run_op("srl_4",     32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000, 0, 1'b0);
        run_op("sra_4",     32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000, 0, 1'b0);
        run_op("sra_31",    32'h7FFF_FFFF, 5'd31, 2'b11, 32'h0000_0000, 0, 1'b0);
        run_op("ror_1",     32'h0000_0001, 5'd1,  2'b01, 32'h8000_0000, 0, 1'b0);
        run_op("ror_4",     32'h0000_00F1, 5'd4,  2'b01, 32'h1000_000F, 0, 1'b0);
        run_op("b0_sll",    32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 0, 1'b0);
        run_op("b0_sra",    32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 0, 1'b0);
        run_op("b0_ror",    32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 0, 1'b0);
        run_op("backpress", 32'hDEAD_BEEF, 5'd8,  2'b10, 32'h00DE_ADBE, 5, 1'b1);

        // Reset while shifting: data must clear without a clock edge.
        in_valid = 1'b1;
        A        = 32'hFFFF_FFFF;
        B        = 5'd20;
        Shiftop  = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_shift_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_shift_result", Result, 32'h0);
        check("rst_shift_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) spur++;
        end
        check("rst_shift_no_spurious", 32'(spur), 32'd0);

        // Reset while a result is pending: out_valid must drop asynchronously.
        in_valid = 1'b1;
        A        = 32'h0000_0005;
        B        = 5'd2;
        Shiftop  = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_done_pending_result", Result, 32'h0000_0014);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done_result", Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            run_op("rand", ra, rb, rop, ref_shift(ra, rb, rop), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
